// File: rtl/match_ctrl.sv
// Two-player match sequencer: button synchronisation, serve/point/game-over flow and scoring.
// Build option: define MATCH_CTRL_AUTOSERVE_EN to serve automatically after SERVE_DELAY cycles.
module match_ctrl #(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned SERVE_DELAY = 50000000,
  parameter int unsigned POINT_HOLD  = 25000000
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       serve_btn,
  input  logic       lose1,
  input  logic       lose2,
  output logic       ball_en,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [2:0] state,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_PLAY       = 3'd2,
    ST_POINT      = 3'd3,
    ST_GAMEOVER   = 3'd4
  } state_t;

  localparam logic [3:0]  WIN_S      = 4'(WIN_SCORE);
  localparam logic [31:0] POINT_LAST = 32'(POINT_HOLD - 1);

  logic       start_meta_r, start_sync_r, start_prev_r;
  logic       serve_meta_r, serve_sync_r, serve_prev_r;
  logic [1:0] warm_r;
  logic       start_edge_s, serve_edge_s;
  logic       unused_cfg_s;

  state_t      state_r, state_n;
  logic [3:0]  score1_r, score1_n, score2_r, score2_n;
  logic [1:0]  winner_r, winner_n;
  logic        dir_r, dir_n;
  logic        ball_en_r, ball_reset_r, ball_reset_n;
  logic [31:0] cnt_r, cnt_n;

  // Button synchronisers; the edge detector is held disarmed until the synchronisers hold real samples
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      start_meta_r <= 1'b0;
      start_sync_r <= 1'b0;
      start_prev_r <= 1'b1;
      serve_meta_r <= 1'b0;
      serve_sync_r <= 1'b0;
      serve_prev_r <= 1'b1;
      warm_r       <= 2'd0;
    end else begin
      start_meta_r <= start_btn;
      start_sync_r <= start_meta_r;
      serve_meta_r <= serve_btn;
      serve_sync_r <= serve_meta_r;
      if (warm_r != 2'd2) begin
        warm_r       <= warm_r + 2'd1;
        start_prev_r <= 1'b1;
        serve_prev_r <= 1'b1;
      end else begin
        start_prev_r <= start_sync_r;
        serve_prev_r <= serve_sync_r;
      end
    end
  end

  assign start_edge_s = start_sync_r & ~start_prev_r;
  assign serve_edge_s = serve_sync_r & ~serve_prev_r;

`ifdef MATCH_CTRL_AUTOSERVE_EN
  localparam logic [31:0] SERVE_LAST = 32'(SERVE_DELAY - 1);
  assign unused_cfg_s = serve_edge_s;
`else
  assign unused_cfg_s = ^32'(SERVE_DELAY);
`endif

  // Next-state, scoring and pulse generation; a start edge overrides everything
  always_comb begin
    state_n      = state_r;
    score1_n     = score1_r;
    score2_n     = score2_r;
    winner_n     = winner_r;
    dir_n        = dir_r;
    cnt_n        = cnt_r;
    ball_reset_n = 1'b0;
    if (start_edge_s) begin
      state_n      = ST_SERVE_WAIT;
      score1_n     = 4'd0;
      score2_n     = 4'd0;
      winner_n     = 2'b00;
      cnt_n        = 32'd0;
      ball_reset_n = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_n = ST_IDLE;
        end
        ST_SERVE_WAIT: begin
`ifdef MATCH_CTRL_AUTOSERVE_EN
          if (cnt_r == SERVE_LAST) begin
            state_n = ST_PLAY;
            cnt_n   = 32'd0;
          end else begin
            cnt_n = cnt_r + 32'd1;
          end
`else
          if (serve_edge_s) begin
            state_n = ST_PLAY;
          end else begin
            state_n = ST_SERVE_WAIT;
          end
          cnt_n = 32'd0;
`endif
        end
        ST_PLAY: begin
          // Simultaneous misses score nothing but still end the rally
          if (lose1 && lose2) begin
            state_n = ST_POINT;
            cnt_n   = 32'd0;
          end else if (lose1) begin
            score2_n = (score2_r < WIN_S) ? score2_r + 4'd1 : score2_r;
            dir_n    = 1'b0;
            state_n  = ST_POINT;
            cnt_n    = 32'd0;
          end else if (lose2) begin
            score1_n = (score1_r < WIN_S) ? score1_r + 4'd1 : score1_r;
            dir_n    = 1'b1;
            state_n  = ST_POINT;
            cnt_n    = 32'd0;
          end else begin
            state_n = ST_PLAY;
          end
        end
        ST_POINT: begin
          if (cnt_r == POINT_LAST) begin
            cnt_n = 32'd0;
            if ((score1_r == WIN_S) || (score2_r == WIN_S)) begin
              state_n  = ST_GAMEOVER;
              winner_n = (score1_r == WIN_S) ? 2'b01 : 2'b10;
            end else begin
              state_n      = ST_SERVE_WAIT;
              ball_reset_n = 1'b1;
            end
          end else begin
            cnt_n = cnt_r + 32'd1;
          end
        end
        ST_GAMEOVER: begin
          state_n = ST_GAMEOVER;
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      score1_r     <= 4'd0;
      score2_r     <= 4'd0;
      winner_r     <= 2'b00;
      dir_r        <= 1'b0;
      cnt_r        <= 32'd0;
      ball_en_r    <= 1'b0;
      ball_reset_r <= 1'b0;
    end else begin
      state_r      <= state_n;
      score1_r     <= score1_n;
      score2_r     <= score2_n;
      winner_r     <= winner_n;
      dir_r        <= dir_n;
      cnt_r        <= cnt_n;
      ball_en_r    <= (state_n == ST_PLAY);
      ball_reset_r <= ball_reset_n;
    end
  end

  assign state      = state_r;
  assign score1     = score1_r;
  assign score2     = score2_r;
  assign winner     = winner_r;
  assign serve_dir  = dir_r;
  assign ball_en    = ball_en_r;
  assign ball_reset = ball_reset_r;

endmodule

// File: tb/tb_match_ctrl.sv
// Scoreboard bench for match_ctrl (WIN_SCORE=3, SERVE_DELAY=4, POINT_HOLD=2); works with or without MATCH_CTRL_AUTOSERVE_EN.
module tb_match_ctrl;

  logic       mclk = 1'b0;
  logic       rst = 1'b0;
  logic       start_btn = 1'b0, serve_btn = 1'b0, lose1 = 1'b0, lose2 = 1'b0;
  logic       ball_en, ball_reset, serve_dir;
  logic [3:0] score1, score2;
  logic [2:0] state;
  logic [1:0] winner;

  match_ctrl #(.WIN_SCORE(3), .SERVE_DELAY(4), .POINT_HOLD(2)) dut (
    .mclk(mclk), .rst(rst), .start_btn(start_btn), .serve_btn(serve_btn),
    .lose1(lose1), .lose2(lose2), .ball_en(ball_en), .ball_reset(ball_reset),
    .serve_dir(serve_dir), .score1(score1), .score2(score2), .state(state), .winner(winner)
  );

  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc++;

  typedef struct {
    int          at;
    logic [15:0] v;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Expected snapshot layout: state, ball_en, ball_reset, serve_dir, score1, score2, winner
  function automatic logic [15:0] pack(logic [2:0] st, logic be, logic br, logic sd,
                                       logic [3:0] s1, logic [3:0] s2, logic [1:0] w);
    return {st, be, br, sd, s1, s2, w};
  endfunction

  task automatic expect_at(input int at, input string name, input logic [2:0] st, input logic be,
                           input logic br, input logic sd, input logic [3:0] s1,
                           input logic [3:0] s2, input logic [1:0] w);
    exp_t e;
    e.at = at; e.name = name; e.v = pack(st, be, br, sd, s1, s2, w);
    q.push_back(e);
  endtask

  // Monitor: pops every expectation due this cycle and compares against the live outputs
  always @(negedge mclk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      exp_t e;
      logic [15:0] act;
      e = q.pop_front();
      act = pack(state, ball_en, ball_reset, serve_dir, score1, score2, winner);
      checks++;
      if (e.at < cyc) begin
        errors++;
        $display("FAIL %s: check scheduled for cycle %0d missed (now %0d)", e.name, e.at, cyc);
      end else if (act !== e.v) begin
        errors++;
        $display("FAIL %s @cyc %0d: got st=%0d en=%b rst=%b dir=%b s1=%0d s2=%0d w=%b, want st=%0d en=%b rst=%b dir=%b s1=%0d s2=%0d w=%b",
                 e.name, cyc, act[15:13], act[12], act[11], act[10], act[9:6], act[5:2], act[1:0],
                 e.v[15:13], e.v[12], e.v[11], e.v[10], e.v[9:6], e.v[5:2], e.v[1:0]);
      end
    end
  end

  logic       m_dir;
  logic [3:0] m_s1, m_s2;
  logic [1:0] m_w;

  task automatic step(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic press_start(output int entry);
    start_btn = 1'b1;
    entry = cyc + 3;
    m_s1 = 4'd0; m_s2 = 4'd0; m_w = 2'b00;
    expect_at(entry, "start_enter", 3'd1, 1'b0, 1'b1, m_dir, 4'd0, 4'd0, 2'b00);
    expect_at(entry + 1, "start_pulse_end", 3'd1, 1'b0, 1'b0, m_dir, 4'd0, 4'd0, 2'b00);
    wait_until(entry + 1);
    start_btn = 1'b0;
  endtask

  task automatic serve(input int entry, output int play);
`ifdef MATCH_CTRL_AUTOSERVE_EN
    play = entry + 4;
    serve_btn = 1'b1;
`else
    play = cyc + 3;
    serve_btn = 1'b1;
`endif
    expect_at(play - 1, "serve_wait", 3'd1, 1'b0, 1'b0, m_dir, m_s1, m_s2, m_w);
    expect_at(play, "serve_play", 3'd2, 1'b1, 1'b0, m_dir, m_s1, m_s2, m_w);
    wait_until(play);
    serve_btn = 1'b0;
  endtask

  task automatic rally(input logic l1, input logic l2, input int play, output int next_entry);
    wait_until(play);
    lose1 = l1; lose2 = l2;
    if (l1 && !l2) begin
      m_s2 = m_s2 + 4'd1; m_dir = 1'b0;
    end else if (l2 && !l1) begin
      m_s1 = m_s1 + 4'd1; m_dir = 1'b1;
    end
    expect_at(play + 1, "point_enter", 3'd3, 1'b0, 1'b0, m_dir, m_s1, m_s2, 2'b00);
    expect_at(play + 2, "point_hold", 3'd3, 1'b0, 1'b0, m_dir, m_s1, m_s2, 2'b00);
    if (m_s1 == 4'd3 || m_s2 == 4'd3) begin
      m_w = (m_s1 == 4'd3) ? 2'b01 : 2'b10;
      expect_at(play + 3, "gameover", 3'd4, 1'b0, 1'b0, m_dir, m_s1, m_s2, m_w);
      next_entry = -1;
    end else begin
      expect_at(play + 3, "point_exit", 3'd1, 1'b0, 1'b1, m_dir, m_s1, m_s2, 2'b00);
      expect_at(play + 4, "reserve_wait", 3'd1, 1'b0, 1'b0, m_dir, m_s1, m_s2, 2'b00);
      next_entry = play + 3;
    end
    step(1);
    lose1 = 1'b0; lose2 = 1'b0;
    wait_until(play + 4);
  endtask

  initial begin
    int c0, entry, play, g;
    m_dir = 1'b0; m_s1 = 4'd0; m_s2 = 4'd0; m_w = 2'b00;

    // start_btn held through reset must not count as a press
    start_btn = 1'b1;
    step(3);
    expect_at(cyc, "reset_values", 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00);
    step(1);
    rst = 1'b1;
    c0 = cyc;
    expect_at(c0 + 5, "no_start_on_release", 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00);
    wait_until(c0 + 6);
    start_btn = 1'b0;
    step(3);

    press_start(entry);
`ifndef MATCH_CTRL_AUTOSERVE_EN
    expect_at(entry + 100, "serve_wait_100", 3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00);
    wait_until(entry + 100);
`endif
    serve(entry, play);
    rally(1'b0, 1'b1, play, entry);   // score1=1, serve toward player 2
    serve(entry, play);
    rally(1'b1, 1'b1, play, entry);   // double miss: nothing changes

    // start during PLAY aborts the match
    serve(entry, play);
    press_start(entry);

    serve(entry, play);
    rally(1'b1, 1'b0, play, entry);
    serve(entry, play);
    rally(1'b1, 1'b0, play, entry);
    serve(entry, play);
    rally(1'b1, 1'b0, play, entry);   // score2 reaches 3: game over, player 2 wins

    g = cyc;
    lose1 = 1'b1;
    expect_at(g + 1, "gameover_saturate", 3'd4, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 2'b10);
    step(1);
    lose1 = 1'b0;
    step(2);

    press_start(entry);
    serve(entry, play);
    rally(1'b0, 1'b1, play, entry);
    serve(entry, play);
    rally(1'b0, 1'b1, play, entry);
    serve(entry, play);
    expect_at(play + 1, "play_before_reset", 3'd2, 1'b1, 1'b0, 1'b1, 4'd2, 4'd0, 2'b00);
    wait_until(play + 1);
    step(1);
    rst = 1'b0;
    expect_at(cyc, "async_reset", 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00);
    step(1);
    expect_at(cyc, "reset_held", 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00);
    step(2);
    rst = 1'b1;
    step(3);

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: check for cycle %0d never reached", e.name, e.at);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/match_ctrl.md
MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 7, points needed to win a match (range 1..15).
REQ-002 Parameter SERVE_DELAY, default 50000000, mclk cycles in SERVE_WAIT before an automatic serve.
REQ-003 Parameter POINT_HOLD, default 25000000, mclk cycles spent in POINT before the next state.
REQ-004 mclk  input  1  system clock; all registers on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start_btn  input  1  asynchronous start/restart button, active-high.
REQ-007 serve_btn  input  1  asynchronous manual serve button, active-high.
REQ-008 lose1  input  1  one-cycle pulse, synchronous to mclk: ball passed player 1's bar.
REQ-009 lose2  input  1  one-cycle pulse, synchronous to mclk: ball passed player 2's bar.
REQ-010 ball_en  output  1  ball motion enable to the VGA display datapath.
REQ-011 ball_reset  output  1  one-cycle pulse that recentres the ball.
REQ-012 serve_dir  output  1  0 = serve toward player 1, 1 = serve toward player 2.
REQ-013 score1, score2  output  4 each  binary point counts for the score board.
REQ-014 state  output  3  encoded FSM state: IDLE=0, SERVE_WAIT=1, PLAY=2, POINT=3, GAMEOVER=4.
REQ-015 winner  output  2  00 = none, 01 = player 1, 10 = player 2.

Function
REQ-016 start_btn and serve_btn SHALL each pass through a 2-flop synchronizer followed by a rising-edge detector; the resulting one-cycle edge SHALL act on the next mclk edge, so state changes 3 edges after the input rises.
REQ-017 IDLE: ball_en=0; a start edge clears both scores and winner, pulses ball_reset, and enters SERVE_WAIT.
REQ-018 SERVE_WAIT: ball_en=0; a 32-bit counter is cleared on entry; the serve condition (REQ-033) moves the FSM to PLAY.
REQ-019 PLAY: ball_en=1 from the first cycle in PLAY; lose1/lose2 are sampled only in this state and ignored in every other state.
REQ-020 lose1 alone: score2 increments, serve_dir<=0, go to POINT, all on the same edge.
REQ-021 lose2 alone: score1 increments, serve_dir<=1, go to POINT, all on the same edge.
REQ-022 lose1 and lose2 in the same cycle: no score change, serve_dir unchanged, go to POINT.
REQ-023 POINT: ball_en=0; after exactly POINT_HOLD cycles go to GAMEOVER if either score equals WIN_SCORE; otherwise pulse ball_reset and go to SERVE_WAIT.
REQ-024 GAMEOVER: ball_en=0; winner is set on entry and held; a start edge behaves as in IDLE.
REQ-025 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-026 ball_reset SHALL be high for exactly one cycle on every entry into SERVE_WAIT and low otherwise.
REQ-027 A start edge in SERVE_WAIT, PLAY or POINT SHALL abort the match: scores cleared, ball_reset pulsed, enter SERVE_WAIT.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 While rst=0: state=IDLE, ball_en=0, ball_reset=0, serve_dir=0, score1=score2=0, winner=00, and all counters and synchronizers cleared.
REQ-030 Release of rst SHALL NOT produce a start edge, even if start_btn is held high.
REQ-031 Reset asserted mid-match SHALL take effect immediately, regardless of mclk.

Configuration
REQ-032 The macro MATCH_CTRL_AUTOSERVE_EN selects the serve mode.
REQ-033 Serve condition: with MATCH_CTRL_AUTOSERVE_EN defined, SERVE_WAIT exits after SERVE_DELAY cycles and serve_btn is ignored; without it, SERVE_WAIT exits only on a serve_btn edge, SERVE_DELAY and its counter are unused, and the FSM waits indefinitely.

Verification (WIN_SCORE=3, SERVE_DELAY=4, POINT_HOLD=2)
REQ-034 Reset release, then start_btn high -> state=1 and a ball_reset pulse 3 edges later; with the macro defined, state=2 and ball_en=1 after 4 further cycles.
REQ-035 In PLAY, pulse lose2 -> score1=1, serve_dir=1, state=3 on the next edge; after 2 cycles, state=1 with a ball_reset pulse.
REQ-036 Three lose1 pulses across three rallies -> score2=3, state=4, winner=10; further lose pulses leave score2=3.
REQ-037 lose1 and lose2 asserted together in PLAY -> scores unchanged, serve_dir unchanged, state=3.
REQ-038 rst driven low mid-PLAY with score1=2 -> all outputs take their reset values without any mclk edge.
REQ-039 Macro undefined: stay in SERVE_WAIT for 100 cycles with serve_btn low; a serve_btn edge then enters PLAY 3 edges after the press.
